mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU execute stage's fetch/load/store request interface.
- Accepts one outstanding request at a time: instruction fetch, data read or data write.
- Serialises the request onto an 8-bit asynchronous-SRAM style external bus with programmable wait states.
- Returns idone/rdone/wdone pulses and read data to the CPU.

Parameters:
- RV, 16, CPU data width; only 16 is legal, other values fail elaboration.
- VA, RV, virtual/physical address width in bits.
- WAIT, 2, extra cycles per external byte access; range 0-15. Each byte phase is WAIT+1 cycles.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ifetch  in  1  fetch request level, held until idone
- pc  in  VA-1  fetch word address, bits [VA-1:1]
- rstrobe  in  2  read request level, byte lanes {hi,lo}, held until rdone
- wmask  in  2  write request level, byte lanes {hi,lo}, held until wdone
- addr  in  VA-1  data word address, bits [VA-1:1]
- wdata  in  16  write data; byte writes arrive replicated on both lanes
- io_access  in  1  current data access targets IO space
- idone  out  1  one-cycle pulse: fetch complete, rdata holds the instruction
- rdone  out  1  one-cycle pulse: read complete, rdata valid
- wdone  out  1  one-cycle pulse: write complete
- rdata  out  16  read/fetch data, valid only while idone or rdone is high
- mem_addr  out  VA  external byte address
- mem_wdata  out  8  external write byte
- mem_rdata  in  8  external read byte
- mem_oe  out  1  external output enable (read)
- mem_we  out  1  external write enable
- mem_io  out  1  IO-space select, held for the whole transaction

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All outputs 0: idone, rdone, wdone, rdata, mem_addr, mem_wdata, mem_oe, mem_we, mem_io.
- Reset asserted mid-transaction aborts the transaction. No done pulse is issued. mem_oe/mem_we are 0 from the next cycle.
- States:
  - IDLE: sample requests in priority order wmask != 0, then rstrobe != 0, then ifetch. Latch the kind, lanes, address, wdata and io_access (io forced 0 for fetch). Go to ACCESS.
  - ACCESS: counter loads WAIT and counts down. mem_addr, mem_wdata, mem_oe/mem_we are stable for all WAIT+1 cycles. Reads capture mem_rdata in the cycle the counter reaches 0.
    - If another lane is pending: reads go straight to the next byte's ACCESS; writes go to GAP.
    - Otherwise go to DONE.
  - GAP: one cycle with mem_we=0 and address held, then ACCESS for the hi byte.
  - DONE: exactly one of idone/rdone/wdone high for one cycle, then IDLE. Requests are not sampled in DONE, because the CPU's request is still high in that cycle. A new request is accepted from the following IDLE cycle.
- Byte ordering is little-endian. Lane lo = byte address {addr,0}; lane hi = {addr,1}. Word accesses do lo first, then hi.
- Fetch is always a full word; rdata = {hi,lo}.
- Word read: rdata = {hi,lo}.
- Byte read (a single rstrobe bit set): the selected byte goes in rdata[7:0], rdata[15:8]=0.
- Write bytes come from wdata[7:0] (lo lane) and wdata[15:8] (hi lane).
- Only lanes whose wmask bit is set are driven on the external bus. wmask==0 with rstrobe==0 is not a data request.
- Latency from request sampled in IDLE at cycle t:
  - byte read/write: done at t+WAIT+2.
  - word read/fetch: done at t+2*WAIT+3.
  - word write: done at t+2*WAIT+4.
- mem_io is set only for data accesses with io_access=1; it is 0 in IDLE and DONE.
- Simultaneous ifetch and data request: the data request is served first, and ifetch stays pending.

Optional Feature:
- Macro: MEM_IBUF_EN.
- When defined: a single-entry fetch buffer holds the tag (pc) and data of the last completed fetch, with a valid bit cleared by reset.
  - A fetch that hits in IDLE goes directly to DONE: idone at t+1, no external cycles.
  - Any write whose addr equals the tag clears valid in that write's IDLE cycle.
  - An IO write never clears valid.
- When undefined: every fetch uses the external bus; no buffer storage is instantiated.

Test Plan:
- Word fetch, WAIT=2: ifetch=1, pc=0x0010; memory at 0x0020=0x34, 0x0021=0x12 -> mem_addr 0x0020 then 0x0021, idone at t+7, rdata=0x1234.
- Byte read hi lane: rstrobe=2'b10, addr=0x0020 -> single byte phase at 0x0041, rdone at t+4, rdata=0x00AB for byte 0xAB.
- Word write: wmask=2'b11, wdata=0xBEEF, addr=0x0008 -> 0xEF to 0x0010 with mem_we=1 for 3 cycles; 1 GAP cycle; 0xBE to 0x0011; wdone at t+8.
- IO byte write plus simultaneous ifetch: wmask=2'b01, io_access=1, ifetch=1 -> write runs first with mem_io=1; wdone; fetch starts only after the following IDLE, with mem_io=0.
- Reset mid word read: reset low during the hi ACCESS -> no rdone; mem_oe=0 next cycle; all outputs 0; a fresh read afterwards completes normally.
- MEM_IBUF_EN: fetch pc=0x0010 twice -> second idone at t+1 with no mem_oe; then write addr=0x0010 and fetch again -> full external fetch, idone at t+7.

Source files
------------

// File: rtl/mem_responder_if.sv
// CPU-side fetch/load/store request and completion signals for mem_responder.
interface mem_responder_if #(
   parameter int unsigned RV = 16,
   parameter int unsigned VA = RV
);
   logic          ifetch;
   logic [VA-2:0] pc;
   logic [1:0]    rstrobe;
   logic [1:0]    wmask;
   logic [VA-2:0] addr;
   logic [RV-1:0] wdata;
   logic          io_access;
   logic          idone;
   logic          rdone;
   logic          wdone;
   logic [RV-1:0] rdata;

   modport master (
      output ifetch, pc, rstrobe, wmask, addr, wdata, io_access,
      input  idone, rdone, wdone, rdata
   );

   modport slave (
      input  ifetch, pc, rstrobe, wmask, addr, wdata, io_access,
      output idone, rdone, wdone, rdata
   );
endinterface

// File: rtl/mem_responder.sv
// Serialises CPU fetch/read/write requests onto an 8-bit async-SRAM bus with wait states.
// Optional single-entry fetch buffer enabled by defining MEM_IBUF_EN.
module mem_responder #(
   parameter int unsigned RV   = 16,
   parameter int unsigned VA   = RV,
   parameter int unsigned WAIT = 2
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave cpu,
   output logic [VA-1:0]  mem_addr,
   output logic [7:0]     mem_wdata,
   input  logic [7:0]     mem_rdata,
   output logic           mem_oe,
   output logic           mem_we,
   output logic           mem_io
);

   if (RV != 16) begin : g_bad_rv
      $fatal(1, "mem_responder: RV must be 16");
   end
   if (WAIT > 15) begin : g_bad_wait
      $fatal(1, "mem_responder: WAIT must be 0..15");
   end

   localparam logic [3:0] WaitCnt = 4'(WAIT);

   typedef enum logic [1:0] {StIdle, StAccess, StGap, StDone} state_e;
   typedef enum logic [1:0] {KindFetch, KindRead, KindWrite} kind_e;

   state_e        state_q, state_d;
   kind_e         kind_q, kind_d;
   logic [1:0]    lanes_q, lanes_d;
   logic          hi_q, hi_d;
   logic [VA-2:0] addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          io_q, io_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [15:0]   data_q, data_d;
   logic          in_bus;

`ifdef MEM_IBUF_EN
   logic          ibuf_valid_q, ibuf_valid_d;
   logic [VA-2:0] ibuf_tag_q, ibuf_tag_d;
   logic [15:0]   ibuf_data_q, ibuf_data_d;
   logic          ibuf_hit;

   assign ibuf_hit = ibuf_valid_q && (ibuf_tag_q == cpu.pc);

   always_ff @(posedge clk) begin
      if (!reset) begin
         ibuf_valid_q <= 1'b0;
         ibuf_tag_q   <= '0;
         ibuf_data_q  <= '0;
      end else begin
         ibuf_valid_q <= ibuf_valid_d;
         ibuf_tag_q   <= ibuf_tag_d;
         ibuf_data_q  <= ibuf_data_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         kind_q  <= KindFetch;
         lanes_q <= 2'b00;
         hi_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         io_q    <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         lanes_q <= lanes_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         io_q    <= io_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      lanes_d = lanes_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      io_d    = io_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
`ifdef MEM_IBUF_EN
      ibuf_valid_d = ibuf_valid_q;
      ibuf_tag_d   = ibuf_tag_q;
      ibuf_data_d  = ibuf_data_q;
`endif
      case (state_q)
         StIdle: begin
            cnt_d  = WaitCnt;
            data_d = '0;
            hi_d   = 1'b0;
            if (cpu.wmask != 2'b00) begin
               kind_d  = KindWrite;
               lanes_d = cpu.wmask;
               hi_d    = ~cpu.wmask[0];
               addr_d  = cpu.addr;
               wdata_d = cpu.wdata;
               io_d    = cpu.io_access;
               state_d = StAccess;
`ifdef MEM_IBUF_EN
               // IO space never aliases instruction memory
               if (!cpu.io_access && (cpu.addr == ibuf_tag_q)) begin
                  ibuf_valid_d = 1'b0;
               end
`endif
            end else if (cpu.rstrobe != 2'b00) begin
               kind_d  = KindRead;
               lanes_d = cpu.rstrobe;
               hi_d    = ~cpu.rstrobe[0];
               addr_d  = cpu.addr;
               io_d    = cpu.io_access;
               state_d = StAccess;
            end else if (cpu.ifetch) begin
               kind_d  = KindFetch;
               lanes_d = 2'b11;
               addr_d  = cpu.pc;
               io_d    = 1'b0;
               state_d = StAccess;
`ifdef MEM_IBUF_EN
               if (ibuf_hit) begin
                  data_d  = ibuf_data_q;
                  state_d = StDone;
               end
`endif
            end
         end
         StAccess: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // A lone hi-lane byte read still returns in the low byte
               if (kind_q != KindWrite) begin
                  if ((lanes_q == 2'b11) && hi_q) begin
                     data_d[15:8] = mem_rdata;
                  end else begin
                     data_d[7:0] = mem_rdata;
                  end
               end
               if (!hi_q && lanes_q[1]) begin
                  if (kind_q == KindWrite) begin
                     state_d = StGap;
                  end else begin
                     hi_d  = 1'b1;
                     cnt_d = WaitCnt;
                  end
               end else begin
                  state_d = StDone;
               end
            end
         end
         StGap: begin
            hi_d    = 1'b1;
            cnt_d   = WaitCnt;
            state_d = StAccess;
         end
         StDone: begin
            state_d = StIdle;
`ifdef MEM_IBUF_EN
            if (kind_q == KindFetch) begin
               ibuf_valid_d = 1'b1;
               ibuf_tag_d   = addr_q;
               ibuf_data_d  = data_q;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_bus    = (state_q == StAccess) || (state_q == StGap);
   assign mem_addr  = in_bus ? {addr_q, hi_q} : '0;
   assign mem_wdata = (in_bus && (kind_q == KindWrite)) ?
                      (hi_q ? wdata_q[15:8] : wdata_q[7:0]) : 8'h00;
   assign mem_oe    = (state_q == StAccess) && (kind_q != KindWrite);
   assign mem_we    = (state_q == StAccess) && (kind_q == KindWrite);
   assign mem_io    = in_bus && io_q;

   assign cpu.idone = (state_q == StDone) && (kind_q == KindFetch);
   assign cpu.rdone = (state_q == StDone) && (kind_q == KindRead);
   assign cpu.wdone = (state_q == StDone) && (kind_q == KindWrite);
   assign cpu.rdata = ((state_q == StDone) && (kind_q != KindWrite)) ? data_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected completions, monitor checks them.
module tb_mem_responder;
   localparam int unsigned W = 2;
`ifdef MEM_IBUF_EN
   localparam bit IBUF = 1'b1;
`else
   localparam bit IBUF = 1'b0;
`endif
   localparam int LatByte = 4;
   localparam int LatWord = 7;
   localparam int LatWr   = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_oe;
   logic        mem_we;
   logic        mem_io;

   logic [7:0] mem [0:255] = '{32: 8'h34, 33: 8'h12, 64: 8'hCD, 65: 8'hAB,
                               96: 8'h11, 97: 8'h22, default: 8'h00};

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int phase_cnt = 0;
   bit io_seen = 1'b0;

   typedef struct {
      int          kind;
      logic [15:0] data;
      int          due;
      int          phases;
      bit          io;
   } exp_t;
   exp_t exp_q[$];

   mem_responder_if #(.RV(16), .VA(16)) bus ();

   mem_responder #(.RV(16), .VA(16), .WAIT(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu       (bus),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_oe    (mem_oe),
      .mem_we    (mem_we),
      .mem_io    (mem_io)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
   end

   assign mem_rdata = mem[mem_addr[7:0]];

   function automatic void chk(string name, int act, int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every done pulse pops one expectation
   always @(negedge clk) begin
      exp_t e;
      int   kind;
      if (mem_oe || mem_we) phase_cnt = phase_cnt + 1;
      if (mem_io) io_seen = 1'b1;
      if (bus.idone || bus.rdone || bus.wdone) begin
         kind = bus.idone ? 0 : (bus.rdone ? 1 : 2);
         chk("done_onehot", int'(bus.idone) + int'(bus.rdone) + int'(bus.wdone), 1);
         if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_done: kind %0d at cycle %0d, none expected", kind, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("done_kind", kind, e.kind);
            chk("rdata", int'(bus.rdata), int'(e.data));
            chk("done_cycle", cyc, e.due);
            chk("bus_phases", phase_cnt, e.phases);
            chk("mem_io", int'(io_seen), int'(e.io));
         end
         phase_cnt = 0;
         io_seen   = 1'b0;
      end
   end

   task automatic idle_req();
      bus.ifetch    = 1'b0;
      bus.rstrobe   = 2'b00;
      bus.wmask     = 2'b00;
      bus.io_access = 1'b0;
   endtask

   task automatic drive(bit f, logic [14:0] p, logic [1:0] rs, logic [1:0] wm,
                        logic [14:0] a, logic [15:0] wd, bit io);
      @(negedge clk);
      bus.ifetch    = f;
      bus.pc        = p;
      bus.rstrobe   = rs;
      bus.wmask     = wm;
      bus.addr      = a;
      bus.wdata     = wd;
      bus.io_access = io;
   endtask

   task automatic push(int kind, logic [15:0] data, int lat, int ph, bit io);
      exp_t e;
      e = '{kind, data, cyc + lat, ph, io};
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.idone || bus.rdone || bus.wdone) got = 1'b1;
      end
      if (!got) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL done_timeout: no done pulse within 40 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic xact(bit f, logic [14:0] p, logic [1:0] rs, logic [1:0] wm, logic [14:0] a,
                       logic [15:0] wd, bit io, int kind, logic [15:0] data, int lat, int ph,
                       bit eio);
      drive(f, p, rs, wm, a, wd, io);
      push(kind, data, lat, ph, eio);
      wait_done();
      idle_req();
   endtask

   initial begin
      bus.pc    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      idle_req();
      repeat (3) @(negedge clk);
      chk("rst_idone", int'(bus.idone), 0);
      chk("rst_rdone", int'(bus.rdone), 0);
      chk("rst_wdone", int'(bus.wdone), 0);
      chk("rst_rdata", int'(bus.rdata), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_mem_wdata", int'(mem_wdata), 0);
      chk("rst_mem_oe", int'(mem_oe), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_mem_io", int'(mem_io), 0);
      reset = 1'b1;

      // word fetch pc=0x10 -> bytes 0x20/0x21
      xact(1, 15'h0010, 2'b00, 2'b00, 15'h0, 16'h0, 0, 0, 16'h1234, LatWord, 6, 0);
      // byte reads, hi then lo lane
      xact(0, 15'h0, 2'b10, 2'b00, 15'h0020, 16'h0, 0, 1, 16'h00AB, LatByte, 3, 0);
      xact(0, 15'h0, 2'b01, 2'b00, 15'h0020, 16'h0, 0, 1, 16'h00CD, LatByte, 3, 0);
      // IO word read
      xact(0, 15'h0, 2'b11, 2'b00, 15'h0030, 16'h0, 1, 1, 16'h2211, LatWord, 6, 1);
      // word write with gap cycle
      xact(0, 15'h0, 2'b00, 2'b11, 15'h0008, 16'hBEEF, 0, 2, 16'h0000, LatWr, 6, 0);
      chk("wr_lo_byte", int'(mem[16]), 8'hEF);
      chk("wr_hi_byte", int'(mem[17]), 8'hBE);
      // hi-lane byte write
      xact(0, 15'h0, 2'b00, 2'b10, 15'h0008, 16'h5A5A, 0, 2, 16'h0000, LatByte, 3, 0);
      chk("bwr_hi_byte", int'(mem[17]), 8'h5A);
      chk("bwr_lo_kept", int'(mem[16]), 8'hEF);
      // repeat fetch: buffer hit when enabled
      xact(1, 15'h0010, 2'b00, 2'b00, 15'h0, 16'h0, 0, 0, 16'h1234,
           IBUF ? 1 : LatWord, IBUF ? 0 : 6, 0);

      // IO byte write with simultaneous fetch: write first, fetch after next IDLE
      drive(1, 15'h0010, 2'b00, 2'b01, 15'h0010, 16'h5555, 1);
      push(2, 16'h0000, LatByte, 3, 1);
      push(0, IBUF ? 16'h1234 : 16'h1255, LatByte + 1 + (IBUF ? 1 : LatWord),
           IBUF ? 0 : 6, 0);
      wait_done();
      bus.wmask     = 2'b00;
      bus.io_access = 1'b0;
      wait_done();
      idle_req();
      chk("io_wr_lo", int'(mem[32]), 8'h55);
      chk("io_wr_hi_kept", int'(mem[33]), 8'h12);

      // write to the buffered pc invalidates it
      xact(0, 15'h0, 2'b00, 2'b11, 15'h0010, 16'hCAFE, 0, 2, 16'h0000, LatWr, 6, 0);
      xact(1, 15'h0010, 2'b00, 2'b00, 15'h0, 16'h0, 0, 0, 16'hCAFE, LatWord, 6, 0);

      // reset during the hi-byte access of a word read
      drive(0, 15'h0, 2'b11, 2'b00, 15'h0010, 16'h0, 0);
      repeat (4) @(negedge clk);
      chk("abort_hi_oe", int'(mem_oe), 1);
      chk("abort_hi_addr", int'(mem_addr), 16'h0021);
      reset = 1'b0;
      idle_req();
      @(negedge clk);
      chk("abort_oe", int'(mem_oe), 0);
      chk("abort_we", int'(mem_we), 0);
      chk("abort_addr", int'(mem_addr), 0);
      chk("abort_io", int'(mem_io), 0);
      chk("abort_rdone", int'(bus.rdone), 0);
      chk("abort_rdata", int'(bus.rdata), 0);
      reset     = 1'b1;
      phase_cnt = 0;
      io_seen   = 1'b0;
      repeat (3) @(negedge clk);
      xact(0, 15'h0, 2'b11, 2'b00, 15'h0010, 16'h0, 0, 1, 16'hCAFE, LatWord, 6, 0);

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
